// File: rtl/data_mem_access.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_access
// Brief   : Memory-stage load/store unit driving a request/ready data bus.
// Revision: 1.0
// ============================================================================
module data_mem_access #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_isValid,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic [DATA_WIDTH-1:0] i_dataB,
  input  logic                  i_memWrEnable,
  input  logic                  i_memRdEnable,
  input  logic [1:0]            i_memAccess,
  input  logic                  i_memUnsigned,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_rdData,
  output logic                  o_rdValid,
  output logic                  o_misaligned,
  output logic [DATA_WIDTH-1:0] o_busAddr,
  output logic [DATA_WIDTH-1:0] o_busWrData,
  output logic [3:0]            o_busByteEn,
  output logic                  o_busWrEnable,
  output logic                  o_busRdEnable,
  input  logic                  i_busReady,
  input  logic [DATA_WIDTH-1:0] i_busRdData
);

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state, w_nextState;

  logic                  w_memOp, w_isStore, w_fault, w_accept;
  logic [3:0]            w_byteEn;
  logic [DATA_WIDTH-1:0] w_wrData, w_shifted, w_loadData;

  logic       r_isLoad, r_keep, r_unsigned;
  logic [1:0] r_size, r_offset;

  assign w_memOp   = i_isValid & (i_memRdEnable | i_memWrEnable);
  assign w_isStore = i_memWrEnable;

  always_comb begin
    w_fault = 1'b0;
    case (i_memAccess)
      c_SIZE_HALF: w_fault = i_result[0];
      c_SIZE_WORD: w_fault = |i_result[1:0];
      c_SIZE_BYTE: w_fault = 1'b0;
      default:     w_fault = 1'b1;
    endcase
  end

  assign w_accept     = w_memOp & ~w_fault & (r_state == IDLE);
  assign o_misaligned = w_memOp & w_fault;
  assign o_stall      = w_memOp & ~w_fault & (r_state != DONE);

  always_comb begin
    w_byteEn = 4'b0000;
    w_wrData = i_dataB;
    case (i_memAccess)
      c_SIZE_BYTE: begin
        w_byteEn = 4'b0001 << i_result[1:0];
        w_wrData = {4{i_dataB[7:0]}};
      end
      c_SIZE_HALF: begin
        w_byteEn = 4'b0011 << i_result[1:0];
        w_wrData = {2{i_dataB[15:0]}};
      end
      default: begin
        w_byteEn = 4'b1111;
        w_wrData = i_dataB;
      end
    endcase
  end

  // Load alignment uses the parameters latched at request time, not live inputs.
  assign w_shifted = i_busRdData >> {r_offset, 3'b000};

  always_comb begin
    w_loadData = w_shifted;
    case (r_size)
      c_SIZE_BYTE: w_loadData = r_unsigned ? {24'd0, w_shifted[7:0]}
                                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
      c_SIZE_HALF: w_loadData = r_unsigned ? {16'd0, w_shifted[15:0]}
                                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default:     w_loadData = w_shifted;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = BUSY;
      BUSY:    if (i_busReady) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_busAddr     <= '0;
      o_busWrData   <= '0;
      o_busByteEn   <= 4'b0000;
      o_busWrEnable <= 1'b0;
      o_busRdEnable <= 1'b0;
      o_rdData      <= '0;
      r_isLoad      <= 1'b0;
      r_keep        <= 1'b0;
      r_unsigned    <= 1'b0;
      r_size        <= 2'b00;
      r_offset      <= 2'b00;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          o_busAddr     <= {i_result[DATA_WIDTH-1:2], 2'b00};
          o_busWrData   <= w_wrData;
          o_busByteEn   <= w_byteEn;
          o_busWrEnable <= w_isStore;
          o_busRdEnable <= ~w_isStore;
          r_isLoad      <= ~w_isStore;
          r_keep        <= 1'b1;
          r_unsigned    <= i_memUnsigned;
          r_size        <= i_memAccess;
          r_offset      <= i_result[1:0];
        end
        BUSY: begin
          // A flush mid-transaction still lets the bus finish, but drops the result.
          if (!i_isValid) r_keep <= 1'b0;
          if (i_busReady) begin
            o_busWrEnable <= 1'b0;
            o_busRdEnable <= 1'b0;
            if (r_isLoad && r_keep && i_isValid) o_rdData <= w_loadData;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rdValid = (r_state == DONE) & r_isLoad & r_keep & i_isValid;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_access
// Brief   : Vector table, directed corner cases and random ops vs. a byte model.
// Revision: 1.0
// ============================================================================
module tb_data_mem_access;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_isValid, i_memWrEnable, i_memRdEnable, i_memUnsigned;
  logic [31:0] i_result, i_dataB, i_busRdData;
  logic [1:0]  i_memAccess;
  logic        i_busReady;
  logic        o_stall, o_rdValid, o_misaligned, o_busWrEnable, o_busRdEnable;
  logic [31:0] o_rdData, o_busAddr, o_busWrData;
  logic [3:0]  o_busByteEn;

  int checks = 0;
  int errors = 0;

  always #5 i_clock = ~i_clock;

  data_mem_access #(.DATA_WIDTH(32)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_isValid(i_isValid),
    .i_result(i_result), .i_dataB(i_dataB), .i_memWrEnable(i_memWrEnable),
    .i_memRdEnable(i_memRdEnable), .i_memAccess(i_memAccess),
    .i_memUnsigned(i_memUnsigned), .o_stall(o_stall), .o_rdData(o_rdData),
    .o_rdValid(o_rdValid), .o_misaligned(o_misaligned), .o_busAddr(o_busAddr),
    .o_busWrData(o_busWrData), .o_busByteEn(o_busByteEn),
    .o_busWrEnable(o_busWrEnable), .o_busRdEnable(o_busRdEnable),
    .i_busReady(i_busReady), .i_busRdData(i_busRdData)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        mem, mis, rdValid;
    logic [31:0] addr, wrData, rdData;
    logic [3:0]  be;
  } exp_t;

  // Reference: works in bytes and plain arithmetic from the access rules.
  function automatic exp_t model(logic [31:0] addr, logic [31:0] d, logic wr, logic rd,
                                 logic valid, logic [1:0] size, logic uns, logic [31:0] bus);
    exp_t e;
    int nb, off;
    longint v;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    e.mem = valid && (wr || rd);
    e.mis = e.mem && (size == 2'd3 || (addr % nb) != 0);
    e.addr = addr - off;
    e.be = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) e.wrData[8*i +: 8] = 8'((d >> (8 * (i % nb))) & 32'hFF);
    v = longint'((bus >> (8 * off))) & ((64'd1 << (8 * nb)) - 1);
    if (!uns && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    e.rdData = v[31:0];
    e.rdValid = e.mem && !e.mis && rd && !wr;
    return e;
  endfunction

  task automatic idleInputs();
    i_isValid = 0; i_memWrEnable = 0; i_memRdEnable = 0; i_busReady = 0;
  endtask

  task automatic runOp(input string nm, input logic [31:0] addr, d, input logic wr, rd, valid,
                       input logic [1:0] size, input logic uns, input logic [31:0] bus,
                       input int waits, input exp_t e);
    int stalls;
    @(posedge i_clock); #1;
    i_result = addr; i_dataB = d; i_memWrEnable = wr; i_memRdEnable = rd;
    i_isValid = valid; i_memAccess = size; i_memUnsigned = uns;
    i_busRdData = bus; i_busReady = 0;
    #1;
    chk({nm, " misaligned"}, 32'(o_misaligned), 32'(e.mis));
    chk({nm, " stall0"}, 32'(o_stall), 32'(e.mem && !e.mis));
    if (!e.mem || e.mis) begin
      @(posedge i_clock); #1;
      chk({nm, " noBusReq"}, 32'(o_busWrEnable | o_busRdEnable), 32'd0);
      idleInputs();
      return;
    end
    stalls = 1;
    for (int w = 0; w <= waits; w++) begin
      @(posedge i_clock); #1;
      chk({nm, " wrEn"}, 32'(o_busWrEnable), 32'(wr));
      chk({nm, " rdEn"}, 32'(o_busRdEnable), 32'(rd && !wr));
      if (w == 0) begin
        chk({nm, " addr"}, o_busAddr, e.addr);
        chk({nm, " byteEn"}, 32'(o_busByteEn), 32'(e.be));
        if (wr) chk({nm, " wrData"}, o_busWrData, e.wrData);
      end
      if (o_stall) stalls++;
      i_busReady = (w == waits);
    end
    @(posedge i_clock); #1;
    i_busReady = 0;
    chk({nm, " stallDone"}, 32'(o_stall), 32'd0);
    chk({nm, " stallCycles"}, 32'(stalls), 32'(waits + 2));
    chk({nm, " rdValid"}, 32'(o_rdValid), 32'(e.rdValid));
    if (e.rdValid) chk({nm, " rdData"}, o_rdData, e.rdData);
    chk({nm, " reqDropped"}, 32'(o_busWrEnable | o_busRdEnable), 32'd0);
    idleInputs();
    @(posedge i_clock); #1;
    chk({nm, " rdValidPulse"}, 32'(o_rdValid), 32'd0);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] addr, d, bus;
    logic        wr, rd, uns;
    logic [1:0]  size;
    int          waits;
    logic        mis, rdValid;
    logic [31:0] eAddr, wrData, rdData;
    logic [3:0]  be;
  } vec_t;

  vec_t vecs[10];

  initial begin
    exp_t e;
    logic [31:0] ra, rdat, rbus;
    logic        rwr, rrd, rval, runs;
    logic [1:0]  rsz;
    int          rsel;

    vecs[0] = '{"wordLd", 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 0, 2'b10, 2, 0, 1, 32'h100, 32'h0, 32'hDEADBEEF, 4'b1111};
    vecs[1] = '{"byteLdS", 32'h203, 32'h0, 32'h80112233, 0, 1, 0, 2'b00, 0, 0, 1, 32'h200, 32'h0, 32'hFFFFFF80, 4'b1000};
    vecs[2] = '{"byteLdU", 32'h203, 32'h0, 32'h80112233, 0, 1, 1, 2'b00, 0, 0, 1, 32'h200, 32'h0, 32'h00000080, 4'b1000};
    vecs[3] = '{"halfSt", 32'h302, 32'h1234ABCD, 32'h0, 1, 0, 0, 2'b01, 1, 0, 0, 32'h300, 32'hABCDABCD, 32'h0, 4'b1100};
    vecs[4] = '{"wordMis", 32'h101, 32'h0, 32'h0, 0, 1, 0, 2'b10, 0, 1, 0, 32'h0, 32'h0, 32'h0, 4'b0000};
    vecs[5] = '{"size11", 32'h100, 32'h0, 32'h0, 0, 1, 0, 2'b11, 0, 1, 0, 32'h0, 32'h0, 32'h0, 4'b0000};
    vecs[6] = '{"bothEn", 32'h40, 32'h55AA1234, 32'h0, 1, 1, 0, 2'b10, 0, 0, 0, 32'h40, 32'h55AA1234, 32'h0, 4'b1111};
    vecs[7] = '{"halfLdS", 32'h102, 32'h0, 32'h80017FFF, 0, 1, 0, 2'b01, 1, 0, 1, 32'h100, 32'h0, 32'hFFFF8001, 4'b1100};
    vecs[8] = '{"halfMis", 32'h103, 32'h0, 32'h0, 0, 1, 0, 2'b01, 0, 1, 0, 32'h0, 32'h0, 32'h0, 4'b0000};
    vecs[9] = '{"byteSt", 32'h11, 32'h000000A5, 32'h0, 1, 0, 0, 2'b00, 3, 0, 0, 32'h10, 32'hA5A5A5A5, 32'h0, 4'b0010};

    i_reset = 1; idleInputs();
    i_result = 0; i_dataB = 0; i_memAccess = 0; i_memUnsigned = 0; i_busRdData = 0;
    #12;
    chk("rst busAddr", o_busAddr, 32'd0);
    chk("rst wrData", o_busWrData, 32'd0);
    chk("rst rdData", o_rdData, 32'd0);
    chk("rst byteEn", 32'(o_busByteEn), 32'd0);
    chk("rst enables", 32'({o_busWrEnable, o_busRdEnable, o_rdValid}), 32'd0);
    #10 i_reset = 0;

    for (int i = 0; i < 10; i++) begin
      e.mem = 1; e.mis = vecs[i].mis; e.rdValid = vecs[i].rdValid;
      e.addr = vecs[i].eAddr; e.wrData = vecs[i].wrData; e.rdData = vecs[i].rdData; e.be = vecs[i].be;
      runOp(vecs[i].nm, vecs[i].addr, vecs[i].d, vecs[i].wr, vecs[i].rd, 1'b1, vecs[i].size,
            vecs[i].uns, vecs[i].bus, vecs[i].waits, e);
    end

    // Asynchronous reset while a read is outstanding.
    @(posedge i_clock); #1;
    i_result = 32'h80; i_memAccess = 2'b10; i_memRdEnable = 1; i_isValid = 1;
    @(posedge i_clock); #1;
    chk("midRst reqUp", 32'(o_busRdEnable), 32'd1);
    #2 i_reset = 1;
    #1;
    chk("midRst reqDrop", 32'(o_busRdEnable | o_busWrEnable), 32'd0);
    chk("midRst byteEn", 32'(o_busByteEn), 32'd0);
    idleInputs();
    #3 i_reset = 0;
    @(posedge i_clock); #1;
    chk("midRst stall", 32'(o_stall), 32'd0);
    chk("midRst idleBus", 32'(o_busRdEnable | o_busWrEnable), 32'd0);
    e = model(32'h84, 32'h0, 0, 1, 1, 2'b10, 0, 32'h0BADF00D);
    runOp("postRst", 32'h84, 32'h0, 0, 1, 1, 2'b10, 0, 32'h0BADF00D, 0, e);

    // Flush during BUSY: transaction completes, result suppressed.
    @(posedge i_clock); #1;
    i_result = 32'h200; i_memAccess = 2'b00; i_memRdEnable = 1; i_isValid = 1;
    i_busRdData = 32'h000000FF;
    @(posedge i_clock); #1;
    chk("flush reqUp", 32'(o_busRdEnable), 32'd1);
    i_isValid = 0; i_busReady = 1;
    @(posedge i_clock); #1;
    i_busReady = 0;
    chk("flush rdValid", 32'(o_rdValid), 32'd0);
    chk("flush reqDrop", 32'(o_busRdEnable), 32'd0);
    chk("flush stall", 32'(o_stall), 32'd0);
    idleInputs();

    for (int n = 0; n < 150; n++) begin
      ra = $urandom; rdat = $urandom; rbus = $urandom;
      rsz = 2'($urandom_range(0, 3)); runs = 1'($urandom_range(0, 1));
      rsel = $urandom_range(0, 3); rrd = rsel[0]; rwr = rsel[1];
      rval = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      e = model(ra, rdat, rwr, rrd, rval, rsz, runs, rbus);
      runOp("rand", ra, rdat, rwr, rrd, rval, rsz, runs, rbus, $urandom_range(0, 3), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
